// File: rtl/mnist_pkg.sv
// Shared definitions for the quantized MNIST datapath.
// Contents:
//   INPUT_SIZE     - elements per image vector (28x28)
//   PIX_W, DATA_W  - raw pixel width and fixed-point element width
//   data_t         - signed fixed-point element type
//   loader_state_t - input loader sequencing states
//   pix_to_fixed   - pixel to fixed-point element conversion
package mnist_pkg;

  localparam int unsigned INPUT_SIZE = 784;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned DATA_W     = 16;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } loader_state_t;

  // Zero-extend the pixel and shift it into the chosen Q format. Shifts of
  // 0..7 keep the sign bit clear, so elements are never negative.
  function automatic data_t pix_to_fixed(input logic [PIX_W-1:0] pix,
                                         input int unsigned      shift);
    logic [DATA_W-1:0] ext_s;
    ext_s = {{(DATA_W-PIX_W){1'b0}}, pix} << shift;
    return $signed(ext_s);
  endfunction

endpackage

// File: rtl/mnist_input_loader.sv
// Input loader for the MNIST datapath. Collects one image as a serial pixel
// stream, converts each pixel to signed fixed point, and hands the complete
// vector to the first fully connected layer with a one-cycle start pulse.
// Ports:
//   clk          - clock, all logic on posedge
//   rstN         - synchronous active-low reset
//   pix_valid    - pixel beat valid
//   pix_data     - unsigned pixel 0..255
//   pix_last     - final pixel of an image
//   pix_ready    - beat accepted when pix_valid & pix_ready
//   layer_done   - completion pulse from the layer
//   vector_out   - buffered image vector, stable while busy
//   vector_valid - one-cycle start pulse to the layer
//   busy         - high from vector_valid until layer_done is accepted
//   err_len      - one-cycle pulse on frame length mismatch
module mnist_input_loader
  import mnist_pkg::*;
#(
  parameter int unsigned INPUT_SIZE = mnist_pkg::INPUT_SIZE,
  parameter int unsigned PIX_SHIFT  = 0
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic             pix_ready,
  input  logic             layer_done,
  output data_t            vector_out [0:INPUT_SIZE-1],
  output logic             vector_valid,
  output logic             busy,
  output logic             err_len
);

  localparam int unsigned      CNT_W    = $clog2(INPUT_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);

  loader_state_t    state_r;
  loader_state_t    state_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic             accept_s;
  logic             err_s;
  logic             pix_ready_r;
  logic             vector_valid_r;
  logic             busy_r;
  logic             err_len_r;
  data_t            buf_r [0:INPUT_SIZE-1];

  assign accept_s = pix_valid && pix_ready_r && (state_r == LOAD);

  // Next-state, element index and length-error decode.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    err_s   = 1'b0;
    case (state_r)
      LOAD: begin
        if (accept_s) begin
          if (count_r == LAST_IDX) begin
            // Buffer full: issue it regardless; a missing last flag means
            // the upstream frame is too long.
            count_s = '0;
            state_s = FIRE;
            err_s   = !pix_last;
          end else if (pix_last) begin
            // Short frame: restart the index so the next frame overwrites
            // the partial data.
            count_s = '0;
            err_s   = 1'b1;
          end else begin
            count_s = count_r + 1'b1;
          end
        end else begin
          state_s = LOAD;
        end
      end
      FIRE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (layer_done) begin
          state_s = LOAD;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = LOAD;
        count_s = '0;
      end
    endcase
  end

  // State, index and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_r        <= LOAD;
      count_r        <= '0;
      pix_ready_r    <= 1'b1;
      vector_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      err_len_r      <= 1'b0;
    end else begin
      state_r        <= state_s;
      count_r        <= count_s;
      // Outputs are derived from the next state so they line up with it.
      pix_ready_r    <= (state_s == LOAD);
      vector_valid_r <= (state_s == FIRE);
      busy_r         <= (state_s != LOAD);
      err_len_r      <= err_s;
    end
  end

  // Vector buffer: one write per accepted beat at the current index.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < int'(INPUT_SIZE); i++) begin
        buf_r[i] <= '0;
      end
    end else if (accept_s) begin
      buf_r[count_r] <= pix_to_fixed(pix_data, PIX_SHIFT);
    end
  end

  assign pix_ready    = pix_ready_r;
  assign vector_valid = vector_valid_r;
  assign busy         = busy_r;
  assign err_len      = err_len_r;
  assign vector_out   = buf_r;

endmodule

// File: tb/tb_mnist_input_loader.sv
// Directed bench for mnist_input_loader. Two instances share the stimulus:
// one with PIX_SHIFT=0 and one with PIX_SHIFT=7.
module tb_mnist_input_loader;
  import mnist_pkg::*;

  logic       clk = 1'b0;
  logic       rstN;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_last;
  logic       layer_done;

  logic  pix_ready0, vector_valid0, busy0, err_len0;
  logic  pix_ready7, vector_valid7, busy7, err_len7;
  data_t vo0 [0:INPUT_SIZE-1];
  data_t vo7 [0:INPUT_SIZE-1];

  always #5 clk = ~clk;

  mnist_input_loader #(.INPUT_SIZE(INPUT_SIZE), .PIX_SHIFT(0)) dut0 (
    .clk(clk), .rstN(rstN), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .pix_ready(pix_ready0), .layer_done(layer_done),
    .vector_out(vo0), .vector_valid(vector_valid0), .busy(busy0),
    .err_len(err_len0)
  );

  mnist_input_loader #(.INPUT_SIZE(INPUT_SIZE), .PIX_SHIFT(7)) dut7 (
    .clk(clk), .rstN(rstN), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_last(pix_last), .pix_ready(pix_ready7), .layer_done(layer_done),
    .vector_out(vo7), .vector_valid(vector_valid7), .busy(busy7),
    .err_len(err_len7)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int vv_cnt   = 0;
  int err_cnt  = 0;

  // Pulse monitor on the unshifted instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (vector_valid0 === 1'b1) vv_cnt++;
    if (err_len0 === 1'b1) err_cnt++;
  end

  typedef struct {
    logic [7:0]  pix;
    logic [15:0] exp0;
    logic [15:0] exp7;
  } conv_t;
  conv_t tab [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix_of(int i, int seed, bit use_tab);
    if (use_tab && i < 6) return tab[i].pix;
    return 8'((i + seed) % 256);
  endfunction

  task automatic send_frame(input int n, input int seed, input int last_at,
                            input bit use_tab);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = pix_of(i, seed, use_tab);
      pix_last  = (i == last_at);
      tick();
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic pulse_done();
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
  endtask

  // Compare every element of both instances against the frame model.
  task automatic check_vec(input string name, input int seed, input bit use_tab);
    int m0 = 0;
    int m7 = 0;
    logic [15:0] e;
    for (int i = 0; i < int'(INPUT_SIZE); i++) begin
      e = {8'h00, pix_of(i, seed, use_tab)};
      if (vo0[i] !== e) m0++;
      if (vo7[i] !== 16'(e * 16'd128)) m7++;
    end
    check({name, " shift0 mismatches"}, m0, 0);
    check({name, " shift7 mismatches"}, m7, 0);
  endtask

  task automatic check_reset_state(input string name);
    int nz = 0;
    for (int i = 0; i < int'(INPUT_SIZE); i++) begin
      if (vo0[i] !== 16'h0000) nz++;
      if (vo7[i] !== 16'h0000) nz++;
    end
    check({name, " pix_ready"}, pix_ready0, 1'b1);
    check({name, " pix_ready7"}, pix_ready7, 1'b1);
    check({name, " vector_valid"}, vector_valid0, 1'b0);
    check({name, " busy"}, busy0, 1'b0);
    check({name, " err_len"}, err_len0, 1'b0);
    check({name, " nonzero elements"}, nz, 0);
  endtask

  initial begin
    int v0, e0, rdy_hi;
    tab[0] = '{8'd0,   16'h0000, 16'h0000};
    tab[1] = '{8'd1,   16'h0001, 16'h0080};
    tab[2] = '{8'd127, 16'h007F, 16'h3F80};
    tab[3] = '{8'd128, 16'h0080, 16'h4000};
    tab[4] = '{8'd200, 16'h00C8, 16'h6400};
    tab[5] = '{8'd255, 16'h00FF, 16'h7F80};

    rstN = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; pix_last = 1'b0;
    layer_done = 1'b0;
    tick(); tick();
    rstN = 1'b1;
    check_reset_state("reset");

    // layer_done in LOAD has no effect.
    pulse_done();
    check("done in LOAD busy", busy0, 1'b0);
    check("done in LOAD pix_ready", pix_ready0, 1'b1);

    // Clean frame with conversion table in the first elements.
    v0 = vv_cnt; e0 = err_cnt;
    send_frame(784, 0, 783, 1'b1);
    check("fire vector_valid", vector_valid0, 1'b1);
    check("fire vector_valid7", vector_valid7, 1'b1);
    check("fire busy", busy0, 1'b1);
    check("fire pix_ready", pix_ready0, 1'b0);
    check("fire err_len", err_len0, 1'b0);
    tick();
    check("wait vector_valid", vector_valid0, 1'b0);
    check("wait busy", busy0, 1'b1);
    check("frame1 valid pulses", vv_cnt - v0, 1);
    check("frame1 err pulses", err_cnt - e0, 0);
    check_vec("frame1", 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("conv%0d shift0", k), vo0[k], tab[k].exp0);
      check($sformatf("conv%0d shift7", k), vo7[k], tab[k].exp7);
    end

    // WAIT ignores incoming beats.
    rdy_hi = 0;
    for (int c = 0; c < 50; c++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(c * 7 + 3);
      tick();
      if (pix_ready0 !== 1'b0) rdy_hi++;
    end
    pix_valid = 1'b0;
    check("wait pix_ready high cycles", rdy_hi, 0);
    check("wait busy held", busy0, 1'b1);
    check_vec("frozen", 0, 1'b1);
    pulse_done();
    check("release pix_ready", pix_ready0, 1'b1);
    check("release busy", busy0, 1'b0);

    // Short frame then clean frame.
    v0 = vv_cnt; e0 = err_cnt;
    send_frame(100, 11, 99, 1'b0);
    check("short err_len", err_len0, 1'b1);
    check("short vector_valid", vector_valid0, 1'b0);
    check("short pix_ready", pix_ready0, 1'b1);
    tick();
    check("short err_len cleared", err_len0, 1'b0);
    send_frame(784, 37, 783, 1'b0);
    check("after short vector_valid", vector_valid0, 1'b1);
    tick();
    check_vec("after short", 37, 1'b0);
    check("short seq valid pulses", vv_cnt - v0, 1);
    check("short seq err pulses", err_cnt - e0, 1);
    pulse_done();

    // Long frame: no pix_last on beat 783.
    v0 = vv_cnt; e0 = err_cnt;
    send_frame(784, 5, -1, 1'b0);
    check("long vector_valid", vector_valid0, 1'b1);
    check("long err_len", err_len0, 1'b1);
    check("long pix_ready", pix_ready0, 1'b0);
    rdy_hi = 0;
    for (int c = 0; c < 10; c++) begin
      pix_valid = 1'b1;
      pix_data  = 8'hAA;
      tick();
      if (pix_ready0 !== 1'b0) rdy_hi++;
    end
    pix_valid = 1'b0;
    check("long extra beats ready", rdy_hi, 0);
    check("long err pulses", err_cnt - e0, 1);
    check("long valid pulses", vv_cnt - v0, 1);
    check_vec("long", 5, 1'b0);
    pulse_done();
    check("long release pix_ready", pix_ready0, 1'b1);

    // Reset mid-load.
    v0 = vv_cnt;
    send_frame(400, 3, -1, 1'b0);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    check_reset_state("reset midload");
    check("midload valid pulses", vv_cnt - v0, 0);

    // Reset during WAIT.
    send_frame(784, 9, 783, 1'b0);
    tick();
    check_vec("pre wait reset", 9, 1'b0);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    check_reset_state("reset in wait");

    // Normal frame after resets.
    v0 = vv_cnt;
    send_frame(784, 21, 783, 1'b0);
    check("post reset vector_valid", vector_valid0, 1'b1);
    tick();
    check_vec("post reset", 21, 1'b0);
    check("post reset valid pulses", vv_cnt - v0, 1);
    pulse_done();
    check("final pix_ready", pix_ready0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
